// File: rtl/vga_scan_controller.sv
// vga_scan_controller: VGA raster timing with a pixel-tick divider and a latency-matched colour/sync output stage
// Ports: clk, reset_n (sync, active-low), pixelData (colour from the pixel source);
//        x/y/active (issued coordinate), pixel_tick, frame_start (pulses),
//        hSync/vSync (active-low), vgaR/vgaG/vgaB (colour drive).
module vga_scan_controller #(
  parameter int H_VISIBLE      = 640,
  parameter int H_FRONT        = 16,
  parameter int H_SYNC         = 96,
  parameter int H_BACK         = 48,
  parameter int V_VISIBLE      = 480,
  parameter int V_FRONT        = 10,
  parameter int V_SYNC         = 2,
  parameter int V_BACK         = 33,
  parameter int BITS_PER_COLOR = 12,
  parameter int PIXEL_DIV      = 4,
  parameter int PIPE_LAT       = 1
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [BITS_PER_COLOR-1:0] pixelData,
  output logic [9:0]                x,
  output logic [8:0]                y,
  output logic                      active,
  output logic                      pixel_tick,
  output logic                      frame_start,
  output logic                      hSync,
  output logic                      vSync,
  output logic [3:0]                vgaR,
  output logic [3:0]                vgaG,
  output logic [3:0]                vgaB
);
  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int DW = PIXEL_DIV > 1 ? $clog2(PIXEL_DIV) : 1;
  localparam logic [DW-1:0] DMAX = DW'(PIXEL_DIV - 1);
  localparam logic [10:0] HMAX = 11'(H_TOTAL - 1);
  localparam logic [10:0] HVIS = 11'(H_VISIBLE);
  localparam logic [10:0] HS0  = 11'(H_VISIBLE + H_FRONT);
  localparam logic [10:0] HS1  = 11'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [10:0] VMAX = 11'(V_TOTAL - 1);
  localparam logic [10:0] VVIS = 11'(V_VISIBLE);
  localparam logic [10:0] VS0  = 11'(V_VISIBLE + V_FRONT);
  localparam logic [10:0] VS1  = 11'(V_VISIBLE + V_FRONT + V_SYNC);
  logic [DW-1:0] div_q, div_d;
  logic tick_q, tick_d;
  logic [10:0] h_q, h_d, v_q, v_d;
  logic [9:0] x_q, x_d;
  logic [8:0] y_q, y_d;
  logic act_q, act_d, fs_q, fs_d;
  logic hs_q, hs_d, vs_q, vs_d;
  logic [11:0] rgb_q, rgb_d;
  // Each stage holds {hsync asserted, vsync asserted, active}; asserted-high so a cleared stage means idle.
  logic [PIPE_LAT-1:0][2:0] pipe_q, pipe_d;
  logic [2:0] raw_d, dly;
  always_comb begin
    div_d  = (div_q == DMAX) ? '0 : div_q + DW'(1);
    // Tick is registered from the next divider value so it is high exactly while div_q == PIXEL_DIV-1.
    tick_d = div_d == DMAX;
    h_d    = tick_q ? ((h_q == HMAX) ? '0 : h_q + 11'd1) : h_q;
    v_d    = (tick_q && h_q == HMAX) ? ((v_q == VMAX) ? '0 : v_q + 11'd1) : v_q;
    act_d  = h_d < HVIS && v_d < VVIS;
    x_d    = (h_d < HVIS) ? h_d[9:0] : '0;
    y_d    = (v_d < VVIS) ? v_d[8:0] : '0;
    fs_d   = tick_d && h_d == HMAX && v_d == VMAX;
    raw_d  = {h_d >= HS0 && h_d < HS1, v_d >= VS0 && v_d < VS1, act_d};
    // Stage 0 tracks the issued coordinate; later stages shift on each tick.
    pipe_d    = pipe_q;
    pipe_d[0] = raw_d;
    for (int k = 1; k < PIPE_LAT; k++)
      if (tick_q) pipe_d[k] = pipe_q[k-1];
    dly   = pipe_q[PIPE_LAT-1];
    hs_d  = tick_q ? !dly[2] : hs_q;
    vs_d  = tick_q ? !dly[1] : vs_q;
    rgb_d = tick_q ? ((dly[0] && !dly[2] && !dly[1]) ? pixelData[11:0] : 12'h000) : rgb_q;
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      div_q  <= '0;
      tick_q <= 1'b0;
      h_q    <= '0;
      v_q    <= '0;
      x_q    <= '0;
      y_q    <= '0;
      act_q  <= 1'b0;
      fs_q   <= 1'b0;
      pipe_q <= '0;
      hs_q   <= 1'b1;
      vs_q   <= 1'b1;
      rgb_q  <= '0;
    end else begin
      div_q  <= div_d;
      tick_q <= tick_d;
      h_q    <= h_d;
      v_q    <= v_d;
      x_q    <= x_d;
      y_q    <= y_d;
      act_q  <= act_d;
      fs_q   <= fs_d;
      pipe_q <= pipe_d;
      hs_q   <= hs_d;
      vs_q   <= vs_d;
      rgb_q  <= rgb_d;
    end
  end
  assign x                  = x_q;
  assign y                  = y_q;
  assign active             = act_q;
  assign pixel_tick         = tick_q;
  assign frame_start        = fs_q;
  assign hSync              = hs_q;
  assign vSync              = vs_q;
  assign {vgaR, vgaG, vgaB} = rgb_q;
endmodule
